hydra_event_fifo: RTL and testbench

HYDRA_EVENT_FIFO -- requirements
Module: hydra_event_fifo

---
 rtl/hydra_event_fifo_pkg.sv | 27 ++
 rtl/hydra_event_fifo_ram.sv | 57 +++++
 rtl/hydra_event_fifo.sv | 142 ++++++++++++++
 tb/tb_hydra_event_fifo.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hydra_event_fifo_pkg.sv
`default_nettype none
//============================================================================
// Module      : hydra_event_fifo_pkg
// Description : Shared hydra constants. Holds the default packet width
//               (including parity), the default pointer width, and the
//               derived depth and half-full threshold. These are used by
//               the event FIFO and by the external comms interface.
// Revision    : 1.0 - initial release
//============================================================================
package hydra_event_fifo_pkg;

    // Packet width including parity. The stored word drops the parity bit.
    localparam int c_HYDRA_WIDTH      = 64;
    localparam int c_HYDRA_WORD_BITS  = c_HYDRA_WIDTH - 1;

    // Pointer width and the depth / threshold derived from it.
    localparam int c_HYDRA_FIFO_BITS  = 11;
    localparam int c_HYDRA_DEPTH      = 2 ** c_HYDRA_FIFO_BITS;
    localparam int c_HYDRA_HALF       = c_HYDRA_DEPTH / 2;

    // Depth for an arbitrary pointer width.
    function automatic int hydra_depth(input int bits);
        return 2 ** bits;
    endfunction

endpackage : hydra_event_fifo_pkg
`default_nettype wire

// File: rtl/hydra_event_fifo_ram.sv
`default_nettype none
//============================================================================
// Module      : fifo_ram
// Description : Simple dual-port storage for the event FIFO.
//               One synchronous write port and one synchronous read port.
//               The read port is read-before-write, so a read and a write
//               to the same address on one edge returns the old word.
// Ports       : clk    - clock, all logic on posedge
//               rst    - synchronous active-high reset (read register only)
//               i_we   - write enable
//               i_waddr/i_wdata - write address / data
//               i_re   - read enable; o_rdata updates only when high
//               i_raddr - read address
//               o_rdata - registered read data
// Revision    : 1.0 - initial release
//============================================================================
module fifo_ram
    import hydra_event_fifo_pkg::*;
#(
    parameter int DATA_BITS = c_HYDRA_WORD_BITS,
    parameter int ADDR_BITS = c_HYDRA_FIFO_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [DATA_BITS-1:0] i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [DATA_BITS-1:0] o_rdata
);

    localparam int c_DEPTH = hydra_depth(ADDR_BITS);

    // Contents are deliberately not reset; the control logic guarantees
    // that nothing written before a reset can be read after it.
    logic [DATA_BITS-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_BITS-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : fifo_ram
`default_nettype wire

// File: rtl/hydra_event_fifo.sv
`default_nettype none
//============================================================================
// Module      : hydra_event_fifo
// Description : Event FIFO between the comms controller and the UART tx
//               path. Circular buffer with wrapping read/write pointers,
//               registered status flags, sticky overflow and a saturating
//               dropped-write counter. Storage lives in fifo_ram.
// Ports       : clk, reset     - clock / synchronous active-high reset
//               data_in        - event word to store
//               write_fifo_n   - active-low write strobe
//               read_fifo_n    - active-low read strobe
//               data_out       - popped word, one cycle after the strobe
//               fifo_empty/half/full - registered occupancy flags
//               fifo_counter   - occupancy 0..DEPTH
//               overflow       - sticky, set on any dropped write
//               drop_count     - dropped writes, saturates at 255
// Revision    : 1.0 - initial release
//============================================================================
module hydra_event_fifo
    import hydra_event_fifo_pkg::*;
#(
    parameter int WIDTH     = c_HYDRA_WIDTH,
    parameter int FIFO_BITS = c_HYDRA_FIFO_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-2:0]     data_in,
    input  logic                 write_fifo_n,
    input  logic                 read_fifo_n,
    output logic [WIDTH-2:0]     data_out,
    output logic                 fifo_empty,
    output logic                 fifo_half,
    output logic                 fifo_full,
    output logic [FIFO_BITS:0]   fifo_counter,
    output logic                 overflow,
    output logic [7:0]           drop_count
);

    // Occupancy constants sized to the counter.
    localparam logic [FIFO_BITS:0]   c_DEPTH   = {1'b1, {FIFO_BITS{1'b0}}};
    localparam logic [FIFO_BITS:0]   c_HALF    = {2'b01, {(FIFO_BITS-1){1'b0}}};
    localparam logic [FIFO_BITS:0]   c_CNT_ONE = {{FIFO_BITS{1'b0}}, 1'b1};
    localparam logic [FIFO_BITS-1:0] c_PTR_ONE = {{(FIFO_BITS-1){1'b0}}, 1'b1};

    logic [FIFO_BITS-1:0] r_wr_ptr;
    logic [FIFO_BITS-1:0] r_rd_ptr;
    logic [FIFO_BITS:0]   r_count;
    logic                 r_empty;
    logic                 r_half;
    logic                 r_full;
    logic                 r_overflow;
    logic [7:0]           r_drop_count;

    logic                 w_wr_req;
    logic                 w_rd_req;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_drop;
    logic                 w_ram_we;
    logic                 w_ram_re;
    logic [FIFO_BITS:0]   w_count_nxt;

    // Request decode. A read is only honoured when something is stored, so
    // on an empty FIFO a simultaneous read/write just stores the word. A
    // write into a full FIFO still succeeds if a read frees a slot on the
    // same edge.
    always_comb begin
        w_wr_req = ~write_fifo_n;
        w_rd_req = ~read_fifo_n;
        w_rd_acc = w_rd_req && (r_count != '0);
        w_wr_acc = w_wr_req && ((r_count != c_DEPTH) || w_rd_acc);
        w_drop   = w_wr_req && !w_wr_acc;
    end

    // Next occupancy; the flags are registered from this so they agree with
    // fifo_counter in the same cycle.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    // Reset wins over any strobe, so the RAM ports are gated by it too.
    assign w_ram_we = w_wr_acc && !reset;
    assign w_ram_re = w_rd_acc && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_half       <= 1'b0;
            r_full       <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_half  <= (w_count_nxt >= c_HALF);
            r_full  <= (w_count_nxt == c_DEPTH);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    fifo_ram #(
        .DATA_BITS (WIDTH - 1),
        .ADDR_BITS (FIFO_BITS)
    ) u_fifo_ram (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_re    (w_ram_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (data_out)
    );

    assign fifo_empty   = r_empty;
    assign fifo_half    = r_half;
    assign fifo_full    = r_full;
    assign fifo_counter = r_count;
    assign overflow     = r_overflow;
    assign drop_count   = r_drop_count;

endmodule : hydra_event_fifo
`default_nettype wire

// File: tb/tb_hydra_event_fifo.sv
`default_nettype none
//============================================================================
// Module      : tb_hydra_event_fifo
// Description : Directed self-checking bench for hydra_event_fifo using the
//               default 63-bit word, 2048-deep configuration.
// Revision    : 1.0 - initial release
//============================================================================
module tb_hydra_event_fifo;

    logic        clk;
    logic        reset;
    logic [62:0] data_in;
    logic        write_fifo_n;
    logic        read_fifo_n;
    logic [62:0] data_out;
    logic        fifo_empty;
    logic        fifo_half;
    logic        fifo_full;
    logic [11:0] fifo_counter;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    hydra_event_fifo #(
        .WIDTH     (64),
        .FIFO_BITS (11)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .write_fifo_n (write_fifo_n),
        .read_fifo_n  (read_fifo_n),
        .data_out     (data_out),
        .fifo_empty   (fifo_empty),
        .fifo_half    (fifo_half),
        .fifo_full    (fifo_full),
        .fifo_counter (fifo_counter),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs change and outputs are read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_fifo_n = 1'b1;
        read_fifo_n  = 1'b1;
        reset        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        write_fifo_n = 1'b1;
        read_fifo_n  = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [62:0] d);
        data_in = d; write_fifo_n = 1'b0; read_fifo_n = 1'b1;
        tick();
        write_fifo_n = 1'b1;
    endtask

    task automatic pop();
        write_fifo_n = 1'b1; read_fifo_n = 1'b0;
        tick();
        read_fifo_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fifo_counter, fifo_empty, fifo_half, fifo_full, overflow, drop_count} !==
            {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_flags: cnt=%0d e=%b h=%b f=%b ov=%b drop=%0d want cnt=0 e=1 h=0 f=0 ov=0 drop=0",
                     fifo_counter, fifo_empty, fifo_half, fifo_full, overflow, drop_count);
        end
        checks++;
        if (data_out !== 63'd0) begin
            failures++;
            $display("FAIL reset_data: got %h want 0", data_out);
        end
    endtask

    task automatic test_basic();
        logic [62:0] exp;
        do_reset();
        push(63'h1); push(63'h2); push(63'h3);
        checks++;
        if (fifo_counter !== 12'd3 || fifo_empty !== 1'b0) begin
            failures++;
            $display("FAIL basic_count3: cnt=%0d e=%b want cnt=3 e=0", fifo_counter, fifo_empty);
        end
        for (int i = 1; i <= 3; i++) begin
            exp = 63'(i);
            pop();
            checks++;
            if (data_out !== exp || fifo_counter !== 12'(3 - i)) begin
                failures++;
                $display("FAIL basic_read%0d: data=%h cnt=%0d want data=%h cnt=%0d",
                         i, data_out, fifo_counter, exp, 3 - i);
            end
        end
        checks++;
        if (fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL basic_empty: got %b want 1", fifo_empty);
        end
    endtask

    task automatic test_half();
        do_reset();
        for (int i = 0; i < 1023; i++) push(63'(i + 10));
        checks++;
        if (fifo_half !== 1'b0 || fifo_counter !== 12'd1023) begin
            failures++;
            $display("FAIL half_before: h=%b cnt=%0d want h=0 cnt=1023", fifo_half, fifo_counter);
        end
        push(63'h7777);
        checks++;
        if (fifo_half !== 1'b1 || fifo_counter !== 12'd1024) begin
            failures++;
            $display("FAIL half_rise: h=%b cnt=%0d want h=1 cnt=1024", fifo_half, fifo_counter);
        end
        pop();
        checks++;
        if (fifo_half !== 1'b0 || fifo_counter !== 12'd1023 || data_out !== 63'd10) begin
            failures++;
            $display("FAIL half_fall: h=%b cnt=%0d data=%h want h=0 cnt=1023 data=a",
                     fifo_half, fifo_counter, data_out);
        end
    endtask

    task automatic test_overflow();
        int bad;
        int dead_seen;
        do_reset();
        for (int i = 0; i < 2048; i++) push(63'h100 + 63'(i));
        checks++;
        if (fifo_full !== 1'b1 || fifo_counter !== 12'd2048 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_fill: f=%b cnt=%0d ov=%b want f=1 cnt=2048 ov=0",
                     fifo_full, fifo_counter, overflow);
        end
        push(63'hDEAD);
        checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b1 || drop_count !== 8'd1 || fifo_counter !== 12'd2048) begin
            failures++;
            $display("FAIL ovf_drop1: f=%b ov=%b drop=%0d cnt=%0d want f=1 ov=1 drop=1 cnt=2048",
                     fifo_full, overflow, drop_count, fifo_counter);
        end
        bad = 0; dead_seen = 0;
        for (int i = 0; i < 2048; i++) begin
            pop();
            if (data_out === 63'hDEAD) dead_seen++;
            if (data_out !== 63'h100 + 63'(i)) bad++;
        end
        checks++;
        if (bad != 0 || dead_seen != 0 || fifo_empty !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drain: wrong=%0d dead=%0d e=%b ov=%b want wrong=0 dead=0 e=1 ov=1",
                     bad, dead_seen, fifo_empty, overflow);
        end
        for (int i = 0; i < 2048; i++) push(63'(i));
        for (int i = 0; i < 253; i++) push(63'h1234);
        checks++;
        if (drop_count !== 8'd254) begin
            failures++;
            $display("FAIL ovf_drop254: got %0d want 254", drop_count);
        end
        for (int i = 0; i < 47; i++) push(63'h1234);
        checks++;
        if (drop_count !== 8'd255 || overflow !== 1'b1 || fifo_counter !== 12'd2048) begin
            failures++;
            $display("FAIL ovf_saturate: drop=%0d ov=%b cnt=%0d want drop=255 ov=1 cnt=2048",
                     drop_count, overflow, fifo_counter);
        end
    endtask

    task automatic test_full_rw();
        int bad;
        do_reset();
        for (int i = 0; i < 2048; i++) push(63'h200 + 63'(i));
        data_in = 63'hBEEF; write_fifo_n = 1'b0; read_fifo_n = 1'b0;
        tick();
        idle();
        checks++;
        if (fifo_counter !== 12'd2048 || fifo_full !== 1'b1 || overflow !== 1'b0 ||
            drop_count !== 8'd0 || data_out !== 63'h200) begin
            failures++;
            $display("FAIL full_rw: cnt=%0d f=%b ov=%b drop=%0d data=%h want cnt=2048 f=1 ov=0 drop=0 data=200",
                     fifo_counter, fifo_full, overflow, drop_count, data_out);
        end
        bad = 0;
        for (int i = 1; i < 2048; i++) begin
            pop();
            if (data_out !== 63'h200 + 63'(i)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_rw_order: wrong=%0d want 0", bad);
        end
        pop();
        checks++;
        if (data_out !== 63'hBEEF || fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL full_rw_last: data=%h e=%b want data=beef e=1", data_out, fifo_empty);
        end
    endtask

    task automatic test_empty_rw();
        // Continues from test_full_rw: empty, data_out holds 0xBEEF.
        pop();
        checks++;
        if (data_out !== 63'hBEEF || fifo_counter !== 12'd0) begin
            failures++;
            $display("FAIL empty_read_ignored: data=%h cnt=%0d want data=beef cnt=0", data_out, fifo_counter);
        end
        data_in = 63'h55; write_fifo_n = 1'b0; read_fifo_n = 1'b0;
        tick();
        idle();
        checks++;
        if (data_out !== 63'hBEEF || fifo_counter !== 12'd1 || fifo_empty !== 1'b0) begin
            failures++;
            $display("FAIL empty_rw: data=%h cnt=%0d e=%b want data=beef cnt=1 e=0",
                     data_out, fifo_counter, fifo_empty);
        end
        pop();
        checks++;
        if (data_out !== 63'h55 || fifo_counter !== 12'd0) begin
            failures++;
            $display("FAIL empty_rw_read: data=%h cnt=%0d want data=55 cnt=0", data_out, fifo_counter);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) push(63'hA0 + 63'(i));
        pop();
        // Write strobe held low through the reset edge.
        data_in = 63'hFF; write_fifo_n = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; write_fifo_n = 1'b1;
        checks++;
        if ({fifo_counter, fifo_empty, fifo_half, fifo_full, overflow, drop_count} !==
            {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0} || data_out !== 63'd0) begin
            failures++;
            $display("FAIL reset_mid: cnt=%0d e=%b h=%b f=%b ov=%b drop=%0d data=%h want all reset values",
                     fifo_counter, fifo_empty, fifo_half, fifo_full, overflow, drop_count, data_out);
        end
        pop();
        checks++;
        if (data_out !== 63'd0 || fifo_counter !== 12'd0 || fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_read: data=%h cnt=%0d e=%b want data=0 cnt=0 e=1",
                     data_out, fifo_counter, fifo_empty);
        end
    endtask

    initial begin
        reset = 1'b1;
        write_fifo_n = 1'b1;
        read_fifo_n = 1'b1;
        data_in = '0;
        test_reset();
        test_basic();
        test_half();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hydra_event_fifo
`default_nettype wire
